// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared constants and helpers for the SRAM-backed FIFO controller
package sram_fifo_pkg;
  localparam int OB_DEPTH = 2;
  function automatic int occWidth(input int depth);
    return $clog2(depth) + 2;
  endfunction
endpackage

// File: rtl/sram_r1_w1_rw0.sv
// sram_r1_w1_rw0: one write port, one synchronous read port (data one cycle after address)
module sram_r1_w1_rw0 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int LG_DEPTH = 6,
  parameter int INIT_VAL = 0
) (
  input  logic                clk,
  input  logic                io_weW_0,
  input  logic [LG_DEPTH-1:0] io_addrW_0,
  input  logic [WIDTH-1:0]    io_dinW_0,
  input  logic [LG_DEPTH-1:0] io_addrR_0,
  output logic [WIDTH-1:0]    io_doutR_0
);
  logic [WIDTH-1:0] mem [DEPTH];
  // power-up value of the read register; the array itself is never cleared
  logic [WIDTH-1:0] doutQ = WIDTH'(INIT_VAL);
  always_ff @(posedge clk) begin
    if (io_weW_0) mem[io_addrW_0] <= io_dinW_0;
    doutQ <= mem[io_addrR_0];
  end
  assign io_doutR_0 = doutQ;
endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: ready/valid FIFO over a 1R1W SRAM with a 2-entry registered output buffer.
// Define SRAM_FIFO_CTRL_HWM_EN to add the io_hwm occupancy high-water-mark port.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int LG_DEPTH = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                io_enq_valid,
  output logic                io_enq_ready,
  input  logic [WIDTH-1:0]    io_enq_bits,
  output logic                io_deq_valid,
  input  logic                io_deq_ready,
  output logic [WIDTH-1:0]    io_deq_bits,
  output logic [LG_DEPTH+1:0] io_count
`ifdef SRAM_FIFO_CTRL_HWM_EN
  ,output logic [LG_DEPTH+1:0] io_hwm
`endif
);
  localparam int CW = occWidth(DEPTH);
  logic [LG_DEPTH-1:0] wrPtr, rdPtr;
  logic [LG_DEPTH:0] sramCnt;
  logic inflight;
  logic [1:0] obCnt, popped, obCntNext;
  logic [WIDTH-1:0] obHead, obTail, obHeadNext, obTailNext, doutR;
  logic [2:0] obNeed;
  logic enqFire, deqFire, rdIssue;
  sram_r1_w1_rw0 #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .LG_DEPTH(LG_DEPTH),
    .INIT_VAL(0)
  ) u_sram (
    .clk(clk),
    .io_weW_0(enqFire),
    .io_addrW_0(wrPtr),
    .io_dinW_0(io_enq_bits),
    .io_addrR_0(rdPtr),
    .io_doutR_0(doutR)
  );
  assign io_enq_ready = sramCnt != (LG_DEPTH+1)'(DEPTH);
  assign io_deq_valid = obCnt != 2'd0;
  assign io_deq_bits = obHead;
  assign io_count = CW'(sramCnt) + CW'(inflight) + CW'(obCnt);
  // a read is only issued when its returning word is guaranteed a buffer slot
  always_comb begin
    enqFire = io_enq_valid & io_enq_ready;
    deqFire = io_deq_valid & io_deq_ready;
    obNeed = 3'(obCnt) + 3'(inflight) - 3'(deqFire);
    rdIssue = (sramCnt != '0) && (obNeed < 3'(OB_DEPTH));
    popped = obCnt - 2'(deqFire);
    obHeadNext = (inflight && popped == 2'd0) ? doutR : deqFire ? obTail : obHead;
    obTailNext = (inflight && popped != 2'd0) ? doutR : obTail;
    obCntNext = popped + 2'(inflight);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      sramCnt <= '0;
      inflight <= 1'b0;
      obCnt <= '0;
      obHead <= '0;
      obTail <= '0;
    end else begin
      wrPtr <= wrPtr + LG_DEPTH'(enqFire);
      rdPtr <= rdPtr + LG_DEPTH'(rdIssue);
      sramCnt <= sramCnt + (LG_DEPTH+1)'(enqFire) - (LG_DEPTH+1)'(rdIssue);
      inflight <= rdIssue;
      obCnt <= obCntNext;
      obHead <= obHeadNext;
      obTail <= obTailNext;
    end
  end
`ifdef SRAM_FIFO_CTRL_HWM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) io_hwm <= '0;
    else if (io_count > io_hwm) io_hwm <= io_count;
  end
`endif
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed and random stimulus with a queue scoreboard and decoupled monitor
module tb_sram_fifo_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int LG_DEPTH = 6;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic io_enq_valid = 1'b0;
  logic io_enq_ready;
  logic [WIDTH-1:0] io_enq_bits = '0;
  logic io_deq_valid;
  logic io_deq_ready = 1'b0;
  logic [WIDTH-1:0] io_deq_bits;
  logic [LG_DEPTH+1:0] io_count;
`ifdef SRAM_FIFO_CTRL_HWM_EN
  logic [LG_DEPTH+1:0] io_hwm;
`endif
  int vectors = 0;
  int miscompares = 0;
  int enqCount = 0;
  int deqCount = 0;
  int maxOcc = 0;
  logic [WIDTH-1:0] lastPop = '0;
  logic [WIDTH-1:0] sb[$];

  sram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LG_DEPTH(LG_DEPTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .io_enq_valid(io_enq_valid),
    .io_enq_ready(io_enq_ready),
    .io_enq_bits(io_enq_bits),
    .io_deq_valid(io_deq_valid),
    .io_deq_ready(io_deq_ready),
    .io_deq_bits(io_deq_bits),
    .io_count(io_count)
`ifdef SRAM_FIFO_CTRL_HWM_EN
    ,.io_hwm(io_hwm)
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // monitor: occupancy and head data checked against the reference queue every cycle
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      maxOcc = 0;
    end else begin
      chk("count", io_count, sb.size());
`ifdef SRAM_FIFO_CTRL_HWM_EN
      chk("hwm", io_hwm, maxOcc);
      if (sb.size() > maxOcc) maxOcc = sb.size();
`endif
      if (io_deq_valid && io_deq_ready) begin
        chk("deq_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          chk("deq_bits", io_deq_bits, sb.pop_front());
          lastPop = io_deq_bits;
          deqCount++;
        end
      end
      if (io_enq_valid && io_enq_ready) begin
        sb.push_back(io_enq_bits);
        enqCount++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(string nm);
    io_enq_valid = 1'b0;
    io_deq_ready = 1'b1;
    for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
    chk(nm, sb.size(), 0);
  endtask

  int start;

  initial begin
    // reset state
    repeat (2) tick();
    samp();
    chk("rst_enq_ready", io_enq_ready, 1);
    chk("rst_deq_valid", io_deq_valid, 0);
    chk("rst_deq_bits", io_deq_bits, 0);
    chk("rst_count", io_count, 0);
    tick();
    reset_n = 1'b1;
    tick();
    // latency: enqueue in cycle 0, visible in cycle 3
    io_enq_valid = 1'b1;
    io_enq_bits = 8'hA5;
    io_deq_ready = 1'b1;
    tick();
    io_enq_valid = 1'b0;
    samp();
    chk("lat_c1_valid", io_deq_valid, 0);
    tick();
    samp();
    chk("lat_c2_valid", io_deq_valid, 0);
    tick();
    samp();
    chk("lat_c3_valid", io_deq_valid, 1);
    chk("lat_c3_bits", io_deq_bits, 8'hA5);
    tick();
    // streaming 0..199 with no bubbles after the initial latency
    for (int c = 0; c < 203; c++) begin
      io_enq_valid = c < 200;
      io_enq_bits = WIDTH'(c);
      samp();
      chk("stream_valid", io_deq_valid, c >= 3);
      tick();
    end
    drain("stream_drain");
    // fill with consumer stalled
    io_deq_ready = 1'b0;
    tick();
    start = enqCount;
    for (int i = 0; i < 70; i++) begin
      io_enq_valid = 1'b1;
      io_enq_bits = WIDTH'(8'h80 + i);
      tick();
    end
    // full: enqueue attempt together with a dequeue
    io_deq_ready = 1'b1;
    samp();
    chk("full_accepted", enqCount - start, DEPTH + 2);
    chk("full_enq_ready", io_enq_ready, 0);
    chk("full_count", io_count, DEPTH + 2);
    tick();
    io_enq_valid = 1'b0;
    io_deq_ready = 1'b0;
    samp();
    chk("full_after_ready", io_enq_ready, 1);
    chk("full_after_count", io_count, DEPTH + 1);
    chk("full_no_overflow", enqCount - start, DEPTH + 2);
    tick();
    drain("fill_drain");
    tick();
    samp();
    chk("empty_deq_valid", io_deq_valid, 0);
    chk("empty_count", io_count, 0);
    tick();
    // asynchronous reset mid-stream with 10 entries queued
    io_deq_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      io_enq_valid = 1'b1;
      io_enq_bits = WIDTH'(8'h30 + i);
      tick();
    end
    io_enq_valid = 1'b0;
    reset_n = 1'b0;
    samp();
    chk("mid_rst_count", io_count, 0);
    chk("mid_rst_deq_valid", io_deq_valid, 0);
    chk("mid_rst_enq_ready", io_enq_ready, 1);
    tick();
    reset_n = 1'b1;
    tick();
    start = deqCount;
    io_enq_valid = 1'b1;
    io_enq_bits = 8'h5A;
    io_deq_ready = 1'b1;
    tick();
    io_enq_valid = 1'b0;
    for (int i = 0; i < 20 && deqCount == start; i++) tick();
    chk("post_rst_deqs", deqCount - start, 1);
    chk("post_rst_first", lastPop, 8'h5A);
    // random valid/ready against the reference queue
    for (int i = 0; i < 10000; i++) begin
      io_enq_valid = $urandom_range(0, 1) != 0;
      io_enq_bits = WIDTH'($urandom);
      io_deq_ready = $urandom_range(0, 1) != 0;
      tick();
    end
    drain("rand_drain");
    tick();
    samp();
    chk("final_deq_valid", io_deq_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
